// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_DEPTH      = 8;

  // Ceiling log2, used to derive pointer and occupancy widths from DEPTH.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH dual-port array: synchronous write, registered read-before-write.
import fifo_pkg::*;

module fifo_ram #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; samples old contents when read and write hit the same entry.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read, occupancy, almost flags
// and overflow/underflow errors. Define FIFO_ERR_STICKY_EN for sticky errors
// cleared by err_clr; otherwise errors are one-cycle pulses.
import fifo_pkg::*;

module fifo_param #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_W     = clog2(DEPTH),
  parameter int unsigned CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic [CNT_W-1:0]      al_empty_thr,
  input  logic [CNT_W-1:0]      al_full_thr,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  al_empty,
  output logic                  al_full,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic              ovf_c;
  logic              unf_c;

  // Flags derived from the occupancy register.
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign al_empty   = (count <= al_empty_thr);
  assign al_full    = (count >= al_full_thr);

  // A read frees a slot, so a write is still accepted at full when paired with a read.
  assign rd_acc_c = fifo_rd & ~fifo_empty;
  assign wr_acc_c = fifo_wr & (~fifo_full | rd_acc_c);
  assign ovf_c    = fifo_wr & ~wr_acc_c;
  assign unf_c    = fifo_rd & ~rd_acc_c;

  // Pointers and occupancy; rejected operations leave them untouched.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read-valid strobe, aligned with the registered read data.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc_c;
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  // Sticky errors; a clear takes priority over a same-cycle set.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (err_clr) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow | ovf_c;
      err_underflow <= err_underflow | unf_c;
    end
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;

  // One-cycle error pulse per rejected request.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= ovf_c;
      err_underflow <= unf_c;
    end
  end
`endif

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .RESET   (RESET),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc_c),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DEPTH=8, DATA_WIDTH=6).
`timescale 1ns/1ps

module tb_fifo_param;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 4;
`ifdef FIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic          clk;
  logic          RESET;
  logic [DW-1:0] data_in;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [CW-1:0] al_empty_thr;
  logic [CW-1:0] al_full_thr;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          al_empty;
  logic          al_full;
  logic [CW-1:0] fifo_count;
  logic          err_overflow;
  logic          err_underflow;

  int total;
  int bad;

  fifo_param dut (
    .clk           (clk),
    .RESET         (RESET),
    .data_in       (data_in),
    .fifo_wr       (fifo_wr),
    .fifo_rd       (fifo_rd),
    .al_empty_thr  (al_empty_thr),
    .al_full_thr   (al_full_thr),
    .err_clr       (err_clr),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .al_empty      (al_empty),
    .al_full       (al_full),
    .fifo_count    (fifo_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1ns after the rising edge.
  task automatic cyc(input logic wr, input logic rd, input logic [DW-1:0] d, input logic clr);
    fifo_wr = wr;
    fifo_rd = rd;
    data_in = d;
    err_clr = clr;
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    RESET        = 1'b1;
    data_in      = '0;
    fifo_wr      = 1'b0;
    fifo_rd      = 1'b0;
    err_clr      = 1'b0;
    al_empty_thr = 4'd2;
    al_full_thr  = 4'd6;
    repeat (2) @(posedge clk);
    #3 RESET = 1'b0;
    @(posedge clk);
    #1;

    // 1. reset state
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_al_empty", 32'(al_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
    check("rst_unf", 32'(err_underflow), 32'd0);

    // 2. write 1..8 then read 8
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, DW'(i), 1'b0);
      check("t2_wcount", 32'(fifo_count), 32'(i));
      check("t2_wfull", 32'(fifo_full), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      check("t2_rdata", 32'(data_out), 32'(i));
      check("t2_rvalid", 32'(valid_out), 32'd1);
      check("t2_rcount", 32'(fifo_count), 32'(8 - i));
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("t2_valid_drop", 32'(valid_out), 32'd0);
    check("t2_hold", 32'(data_out), 32'd8);
    check("t2_empty", 32'(fifo_empty), 32'd1);

    // 3. full then simultaneous rd+wr of 0x2A
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
    check("t3_full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 6'h2A, 1'b0);
      check("t3_rw_data", 32'(data_out), 32'(8'h10 + i));
      check("t3_rw_count", 32'(fifo_count), 32'd8);
      check("t3_rw_ovf", 32'(err_overflow), 32'd0);
      check("t3_rw_unf", 32'(err_underflow), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      check("t3_2a_data", 32'(data_out), 32'h2A);
    end
    check("t3_empty", 32'(fifo_empty), 32'd1);

    // 4. overflow / underflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
    cyc(1'b1, 1'b0, 6'h15, 1'b0);
    check("t4_ovf", 32'(err_overflow), 32'd1);
    check("t4_ovf_count", 32'(fifo_count), 32'd8);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("t4_ovf_after", 32'(err_overflow), 32'(STICKY));
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("t4_ovf_clr", 32'(err_overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      check("t4_drain", 32'(data_out), 32'(8'h20 + i));
    end
    cyc(1'b0, 1'b1, '0, 1'b0);
    check("t4_unf", 32'(err_underflow), 32'd1);
    check("t4_unf_valid", 32'(valid_out), 32'd0);
    check("t4_unf_count", 32'(fifo_count), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("t4_unf_after", 32'(err_underflow), 32'(STICKY));
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("t4_unf_clr", 32'(err_underflow), 32'd0);
    cyc(1'b1, 1'b1, 6'h05, 1'b0);
    check("t4_erw_count", 32'(fifo_count), 32'd1);
    check("t4_erw_unf", 32'(err_underflow), 32'd1);
    check("t4_erw_valid", 32'(valid_out), 32'd0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    check("t4_erw_data", 32'(data_out), 32'h05);
    check("t4_erw_valid2", 32'(valid_out), 32'd1);
    check("t4_erw_unf2", 32'(err_underflow), 32'(STICKY));
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("t4_erw_clr", 32'(err_underflow), 32'd0);

    // 5. almost thresholds across count 0..8
    check("t5_ae_0", 32'(al_empty), 32'd1);
    check("t5_af_0", 32'(al_full), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b1, 1'b0, DW'(c), 1'b0);
      check("t5_ae", 32'(al_empty), (c <= 2) ? 32'd1 : 32'd0);
      check("t5_af", 32'(al_full), (c >= 6) ? 32'd1 : 32'd0);
    end
    for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, '0, 1'b0);
    check("t5_drained", 32'(fifo_count), 32'd0);

    // 6. asynchronous reset mid-burst at count 5
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
    cyc(1'b1, 1'b1, 6'h36, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    check("t6_pre_count", 32'(fifo_count), 32'd5);
    check("t6_pre_valid", 32'(valid_out), 32'd1);
    check("t6_pre_data", 32'(data_out), 32'h31);
    #2 RESET = 1'b1;
    #1;
    check("t6_async_count", 32'(fifo_count), 32'd0);
    check("t6_async_empty", 32'(fifo_empty), 32'd1);
    check("t6_async_valid", 32'(valid_out), 32'd0);
    check("t6_async_data", 32'(data_out), 32'd0);
    @(posedge clk);
    #3 RESET = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 6'h3F, 1'b0);
    check("t6_new_count", 32'(fifo_count), 32'd1);
    cyc(1'b0, 1'b1, '0, 1'b0);
    check("t6_new_data", 32'(data_out), 32'h3F);
    check("t6_new_empty", 32'(fifo_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
